// File: rtl/dlx_defs.sv
// Shared DLX pipeline definitions: opcodes, control-tuple layout and the decode table.
package dlx_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   // Bit positions inside the ex / m / wb control fields.
   localparam int EX_REG_DST   = 3;
   localparam int M_MEM_READ   = 1;
   localparam int WB_REG_WRITE = 1;

   typedef struct packed {
      logic [3:0] ex;  // {reg_dst, alu_src, alu_op[1:0]}
      logic [1:0] m;   // {mem_read, mem_write}
      logic [1:0] wb;  // {reg_write, mem_to_reg}
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   function automatic ctrl_t decode_ctrl(input logic [5:0] op);
      ctrl_t c;
      c = CTRL_BUBBLE;
      case (op)
         OP_RTYPE: c = '{ex: 4'b1010, m: 2'b00, wb: 2'b10};
         OP_ADDI:  c = '{ex: 4'b0100, m: 2'b00, wb: 2'b10};
         OP_LW:    c = '{ex: 4'b0100, m: 2'b10, wb: 2'b11};
         OP_SW:    c = '{ex: 4'b0100, m: 2'b01, wb: 2'b00};
         OP_BEQ,
         OP_BNE:   c = '{ex: 4'b0001, m: 2'b00, wb: 2'b00};
         default:  c = CTRL_BUBBLE;
      endcase
      return c;
   endfunction

   // Opcodes that read rt as a source operand (rather than writing it).
   function automatic logic rt_is_source(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/reg_bank_bypass.sv
// Register bank with two combinational read ports and same-cycle write-through from WB.
// Register 0 and addresses at or above NREG always read as zero.
module reg_bank_bypass #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [4:0]        i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [4:0]        i_raddr_a,
   input  logic [4:0]        i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b
);

   logic [DATA_W-1:0] r_regs [NREG];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (i_we && (i_waddr != 5'd0) && (int'(i_waddr) < NREG)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      o_rdata_a = '0;
      if ((i_raddr_a != 5'd0) && (int'(i_raddr_a) < NREG)) begin
         o_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : r_regs[i_raddr_a];
      end
   end

   always_comb begin
      o_rdata_b = '0;
      if ((i_raddr_b != 5'd0) && (int'(i_raddr_b) < NREG)) begin
         o_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : r_regs[i_raddr_b];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// DLX ID stage: decode, register read with WB bypass, branch resolution in ID,
// load-use / branch-operand hazard stall, and the ID/EX pipeline register.
module decode_stage
   import dlx_defs::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 10,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       if_instr,
   input  logic [PC_W-1:0]   if_pc,
   input  logic              if_valid,
   input  logic              wb_we,
   input  logic [4:0]        wb_rw,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mem_reg_write,
   input  logic [4:0]        mem_dest,
   output logic              stall,
   output logic              pc_sel,
   output logic [PC_W-1:0]   branch_target,
   output logic              ex_valid,
   output logic [3:0]        ex_ctrl,
   output logic [1:0]        m_ctrl,
   output logic [1:0]        wb_ctrl,
   output logic [DATA_W-1:0] ex_bus_a,
   output logic [DATA_W-1:0] ex_bus_b,
   output logic [DATA_W-1:0] ex_immed,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd
);

   logic [5:0]        w_opcode;
   logic [4:0]        w_rs, w_rt, w_rd;
   logic [DATA_W-1:0] w_immed;
   logic [DATA_W-1:0] w_bus_a, w_bus_b;
   ctrl_t             w_ctrl;
   logic              w_is_beq, w_is_bne, w_is_branch;
   logic [4:0]        w_ex_dest;
   logic              w_ex_writes;
   logic              w_load_use, w_rs_busy, w_rt_busy, w_branch_haz, w_stall;

   logic              r_ex_valid;
   ctrl_t             r_ctrl;
   logic [DATA_W-1:0] r_bus_a, r_bus_b, r_immed;
   logic [4:0]        r_rs, r_rt, r_rd;

   assign w_opcode = if_instr[31:26];
   assign w_rs     = if_instr[25:21];
   assign w_rt     = if_instr[20:16];
   assign w_rd     = if_instr[15:11];
   assign w_immed  = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};
   assign w_ctrl   = decode_ctrl(w_opcode);

   assign w_is_beq    = (w_opcode == OP_BEQ);
   assign w_is_bne    = (w_opcode == OP_BNE);
   assign w_is_branch = w_is_beq || w_is_bne;

   reg_bank_bypass #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_regs (
      .i_clk     (clk),
      .i_rst     (reset),
      .i_we      (wb_we),
      .i_waddr   (wb_rw),
      .i_wdata   (wb_data),
      .i_raddr_a (w_rs),
      .i_raddr_b (w_rt),
      .o_rdata_a (w_bus_a),
      .o_rdata_b (w_bus_b)
   );

   // A bubble carries zero ctrl, so it never matches as a writer or a load.
   assign w_ex_dest   = r_ctrl.ex[EX_REG_DST] ? r_rd : r_rt;
   assign w_ex_writes = r_ex_valid && r_ctrl.wb[WB_REG_WRITE];

   assign w_load_use = if_valid && r_ex_valid && r_ctrl.m[M_MEM_READ] && (w_ex_dest != 5'd0) &&
                       ((w_ex_dest == w_rs) || ((w_ex_dest == w_rt) && rt_is_source(w_opcode)));

   // Branches compare in ID, so any in-flight producer of an operand must drain to WB first.
   assign w_rs_busy = (w_rs != 5'd0) &&
                      ((w_ex_writes && (w_ex_dest == w_rs)) || (mem_reg_write && (mem_dest == w_rs)));
   assign w_rt_busy = (w_rt != 5'd0) &&
                      ((w_ex_writes && (w_ex_dest == w_rt)) || (mem_reg_write && (mem_dest == w_rt)));
   assign w_branch_haz = if_valid && w_is_branch && (w_rs_busy || w_rt_busy);

   assign w_stall = w_load_use || w_branch_haz;

   assign stall         = w_stall;
   assign pc_sel        = if_valid && !w_stall &&
                          ((w_is_beq && (w_bus_a == w_bus_b)) || (w_is_bne && (w_bus_a != w_bus_b)));
   assign branch_target = if_pc + w_immed[PC_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex_valid <= 1'b0;
         r_ctrl     <= CTRL_BUBBLE;
         r_bus_a    <= '0;
         r_bus_b    <= '0;
         r_immed    <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
      end else if (w_stall || !if_valid) begin
         r_ex_valid <= 1'b0;
         r_ctrl     <= CTRL_BUBBLE;
      end else begin
         r_ex_valid <= 1'b1;
         r_ctrl     <= w_ctrl;
         r_bus_a    <= w_bus_a;
         r_bus_b    <= w_bus_b;
         r_immed    <= w_immed;
         r_rs       <= w_rs;
         r_rt       <= w_rt;
         r_rd       <= w_rd;
      end
   end

   assign ex_valid = r_ex_valid;
   assign ex_ctrl  = r_ctrl.ex;
   assign m_ctrl   = r_ctrl.m;
   assign wb_ctrl  = r_ctrl.wb;
   assign ex_bus_a = r_bus_a;
   assign ex_bus_b = r_bus_b;
   assign ex_immed = r_immed;
   assign ex_rs    = r_rs;
   assign ex_rt    = r_rt;
   assign ex_rd    = r_rd;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic checked against a
// behavioural model (architectural register array + predicted ID/EX contents queue).
module tb_decode_stage;

   localparam int DATA_W = 32;
   localparam int PC_W   = 10;
   localparam int EXP_W  = 1 + 8 + 3*DATA_W + 15;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       if_instr;
   logic [PC_W-1:0]   if_pc;
   logic              if_valid;
   logic              wb_we;
   logic [4:0]        wb_rw;
   logic [DATA_W-1:0] wb_data;
   logic              mem_reg_write;
   logic [4:0]        mem_dest;
   logic              stall, pc_sel, ex_valid;
   logic [PC_W-1:0]   branch_target;
   logic [3:0]        ex_ctrl;
   logic [1:0]        m_ctrl, wb_ctrl;
   logic [DATA_W-1:0] ex_bus_a, ex_bus_b, ex_immed;
   logic [4:0]        ex_rs, ex_rt, ex_rd;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
      .wb_we(wb_we), .wb_rw(wb_rw), .wb_data(wb_data),
      .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
      .stall(stall), .pc_sel(pc_sel), .branch_target(branch_target),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .m_ctrl(m_ctrl), .wb_ctrl(wb_ctrl),
      .ex_bus_a(ex_bus_a), .ex_bus_b(ex_bus_b), .ex_immed(ex_immed),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [EXP_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DATA_W-1:0] m_regs [32];
   logic              m_v;
   logic [7:0]        m_ctrl_q;   // {reg_dst, alu_src, alu_op[1:0], mem_read, mem_write, reg_write, mem_to_reg}
   logic [DATA_W-1:0] m_a, m_b, m_imm;
   logic [4:0]        m_rs, m_rt, m_rd;
   logic              e_stall, e_pc_sel;
   logic [PC_W-1:0]   e_target;
   logic              obs_stall, obs_pc_sel;

   function automatic logic [7:0] ref_ctrl(input logic [5:0] op);
      case (op)
         6'h00:        return 8'b1010_00_10;
         6'h08:        return 8'b0100_00_10;
         6'h23:        return 8'b0100_10_11;
         6'h2B:        return 8'b0100_01_00;
         6'h04, 6'h05: return 8'b0001_00_00;
         default:      return 8'h00;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] ref_read(input logic [4:0] addr);
      if (addr == 0) return '0;
      if (wb_we && wb_rw == addr) return wb_data;
      return m_regs[addr];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      {m_v, m_ctrl_q, m_a, m_b, m_imm, m_rs, m_rt, m_rd} = '0;
      exp_q.delete();
   endtask

   task automatic model_eval();
      logic [5:0] op;
      logic [4:0] rs, rt, dest;
      logic [DATA_W-1:0] a, b, imm;
      logic lu, bh, rt_src, ex_w, rs_busy, rt_busy;
      int tgt;
      op   = if_instr[31:26];
      rs   = if_instr[25:21];
      rt   = if_instr[20:16];
      imm  = {{16{if_instr[15]}}, if_instr[15:0]};
      a    = ref_read(rs);
      b    = ref_read(rt);
      dest = m_ctrl_q[7] ? m_rd : m_rt;
      ex_w = m_v && m_ctrl_q[1];
      rt_src  = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
      lu      = if_valid && m_v && m_ctrl_q[3] && dest != 0 && (dest == rs || (rt_src && dest == rt));
      rs_busy = rs != 0 && ((ex_w && dest == rs) || (mem_reg_write && mem_dest == rs));
      rt_busy = rt != 0 && ((ex_w && dest == rt) || (mem_reg_write && mem_dest == rt));
      bh      = if_valid && (op == 6'h04 || op == 6'h05) && (rs_busy || rt_busy);
      e_stall  = lu || bh;
      e_pc_sel = if_valid && !e_stall && ((op == 6'h04 && a == b) || (op == 6'h05 && a != b));
      tgt      = int'(if_pc) + int'($signed(if_instr[15:0]));
      e_target = PC_W'(tgt & ((1 << PC_W) - 1));
      if (e_stall || !if_valid)
         exp_q.push_back({1'b0, 8'h00, m_a, m_b, m_imm, m_rs, m_rt, m_rd});
      else
         exp_q.push_back({1'b1, ref_ctrl(op), a, b, imm, rs, rt, if_instr[15:11]});
   endtask

   // One cycle: check combinational outputs, clock, then check ID/EX against the queue head.
   task automatic step();
      logic [EXP_W-1:0] w;
      #1;
      model_eval();
      obs_stall  = stall;
      obs_pc_sel = pc_sel;
      check("stall", stall, e_stall);
      check("pc_sel", pc_sel, e_pc_sel);
      check("branch_target", branch_target, e_target);
      @(posedge clk);
      if (wb_we && wb_rw != 0) m_regs[wb_rw] = wb_data;
      #1;
      w = exp_q.pop_front();
      {m_v, m_ctrl_q, m_a, m_b, m_imm, m_rs, m_rt, m_rd} = w;
      check("ex_valid", ex_valid, m_v);
      check("ctrl", {ex_ctrl, m_ctrl, wb_ctrl}, m_ctrl_q);
      if (m_v) begin
         check("ex_bus_a", ex_bus_a, m_a);
         check("ex_bus_b", ex_bus_b, m_b);
         check("ex_immed", ex_immed, m_imm);
         check("ex_regs", {ex_rs, ex_rt, ex_rd}, {m_rs, m_rt, m_rd});
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive(input logic [31:0] ins, input logic [PC_W-1:0] pc, input logic v,
                        input logic we, input logic [4:0] rw, input logic [DATA_W-1:0] wd,
                        input logic mw, input logic [4:0] md);
      @(negedge clk);
      if_instr = ins; if_pc = pc; if_valid = v;
      wb_we = we; wb_rw = rw; wb_data = wd;
      mem_reg_write = mw; mem_dest = md;
      step();
   endtask

   task automatic idle();
      drive(32'h0, '0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
   endtask

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0] op;
      case ($urandom_range(0, 6))
         0: op = 6'h00;
         1: op = 6'h08;
         2: op = 6'h23;
         3: op = 6'h2B;
         4: op = 6'h04;
         5: op = 6'h05;
         default: op = 6'($urandom_range(0, 63));
      endcase
      if (op == 6'h00)
         return r_ins(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      return i_ins(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      case ($urandom_range(0, 3))
         0: return '0;
         1: return 1;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      if_instr = '0; if_pc = '0; if_valid = 1'b0;
      wb_we = 1'b0; wb_rw = '0; wb_data = '0;
      mem_reg_write = 1'b0; mem_dest = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ex_valid", ex_valid, 1'b0);
      check("rst_ctrl", {ex_ctrl, m_ctrl, wb_ctrl}, 8'h00);
      check("rst_data", {ex_bus_a, ex_bus_b, ex_immed}, '0);
      check("rst_regs", {ex_rs, ex_rt, ex_rd}, 15'd0);
      @(negedge clk);
      reset = 1'b0;

      // WB bypass on a same-cycle read, and writes to r0 are dropped.
      drive(r_ins(5'd5, 5'd0, 5'd9), 10'd1, 1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
      check("bypass_r5", ex_bus_a, 32'h1234);
      drive(r_ins(5'd0, 5'd0, 5'd1), 10'd2, 1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0);
      check("r0_bypass", ex_bus_a, 32'h0);
      drive(r_ins(5'd0, 5'd5, 5'd1), 10'd3, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      check("r0_after", ex_bus_a, 32'h0);
      check("r5_stored", ex_bus_b, 32'h1234);

      // Load-use: LW r2,0(r1) then ADD r3,r2,r4.
      drive(i_ins(6'h23, 5'd1, 5'd2, 16'd0), 10'd4, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      drive(r_ins(5'd2, 5'd4, 5'd3), 10'd5, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      check("lu_stall", obs_stall, 1'b1);
      check("lu_bubble", ex_valid, 1'b0);
      drive(r_ins(5'd2, 5'd4, 5'd3), 10'd5, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      check("lu_released", obs_stall, 1'b0);
      check("lu_add_in_ex", {ex_valid, ex_rd}, {1'b1, 5'd3});

      // Branch target wrap and BNE with equal operands.
      idle();
      drive(i_ins(6'h04, 5'd1, 5'd1, 16'd5), 10'h3FE, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      check("beq_taken", obs_pc_sel, 1'b1);
      check("beq_wrap", branch_target, 10'h003);
      drive(i_ins(6'h05, 5'd1, 5'd1, 16'd5), 10'h3FE, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      check("bne_equal", obs_pc_sel, 1'b0);

      // Branch operand in flight: ADDI r7 in EX, then in MEM, then resolved from WB bypass.
      drive(32'h0, 10'd0, 1'b0, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0);
      drive(i_ins(6'h08, 5'd0, 5'd7, 16'd0), 10'h10, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      drive(i_ins(6'h04, 5'd7, 5'd0, 16'd2), 10'h11, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      check("br_ex_stall", obs_stall, 1'b1);
      drive(i_ins(6'h04, 5'd7, 5'd0, 16'd2), 10'h11, 1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd7);
      check("br_mem_stall", obs_stall, 1'b1);
      drive(i_ins(6'h04, 5'd7, 5'd0, 16'd2), 10'h11, 1'b1, 1'b1, 5'd7, 32'h0, 1'b0, 5'd0);
      check("br_wb_nostall", obs_stall, 1'b0);
      check("br_wb_taken", obs_pc_sel, 1'b1);

      // Unknown opcode travels as a valid NOP; an invalid slot is a bubble.
      drive(i_ins(6'h3F, 5'd1, 5'd2, 16'h1234), 10'h20, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      check("unk_valid", ex_valid, 1'b1);
      check("unk_ctrl", {ex_ctrl, m_ctrl, wb_ctrl}, 8'h00);
      drive(i_ins(6'h04, 5'd0, 5'd0, 16'd1), 10'h21, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      check("inv_pc_sel", obs_pc_sel, 1'b0);
      check("inv_bubble", ex_valid, 1'b0);

      // Random traffic; a stalled instruction is held in IF/ID as the real front end would.
      begin
         logic [31:0] ins = rand_instr();
         logic [PC_W-1:0] pc = PC_W'($urandom);
         logic v = 1'b1;
         for (int i = 0; i < 400; i++) begin
            drive(ins, pc, v,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), rand_data(),
                  ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)));
            if (!e_stall) begin
               ins = rand_instr();
               pc  = PC_W'($urandom);
               v   = ($urandom_range(0, 99) < 85);
            end
         end
      end

      // Reset in the middle of traffic: async clear of ID/EX, then every register reads 0.
      drive(i_ins(6'h23, 5'd1, 5'd3, 16'd4), 10'h40, 1'b1, 1'b1, 5'd6, 32'hABCD, 1'b0, 5'd0);
      @(negedge clk);
      wb_we = 1'b0; if_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("midrst_ex_valid", ex_valid, 1'b0);
      check("midrst_ctrl", {ex_ctrl, m_ctrl, wb_ctrl}, 8'h00);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int r = 1; r < 32; r++) begin
         drive(r_ins(5'(r), 5'(r), 5'd0), 10'h50, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0);
         check("post_rst_read", {ex_bus_a, ex_bus_b}, 64'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor of the single-cycle decode block; it owns the ID stage of the 5-stage MIPS/DLX pipeline and the ID/EX pipeline register.
- Decodes the instruction and reads the internal register bank, with write-through bypass from WB.
- Resolves BEQ/BNE in ID and computes the branch target.
- Detects load-use and branch-operand hazards, stalls IF/ID and inserts bubbles into EX.

Parameters:
- DATA_W, 32, register and bus width.
- PC_W, 10, PC and branch-target width (word addresses).
- NREG, 32, register count; register 0 reads as zero. Register addresses are always 5 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_instr  in  32  IF/ID instruction.
- if_pc  in  PC_W  IF/ID PC, already incremented (PC+1).
- if_valid  in  1  IF/ID slot holds a real instruction.
- wb_we  in  1  WB register write enable.
- wb_rw  in  5  WB destination register.
- wb_data  in  DATA_W  WB write data.
- mem_reg_write  in  1  MEM-stage instruction writes a register.
- mem_dest  in  5  MEM-stage destination.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- pc_sel  out  1  branch taken: IF loads branch_target and flushes IF/ID (combinational).
- branch_target  out  PC_W  if_pc + immed[PC_W-1:0], modulo 2^PC_W.
- ex_valid  out  1  ID/EX slot valid.
- ex_ctrl  out  4  {reg_dst, alu_src, alu_op[1:0]}.
- m_ctrl  out  2  {mem_read, mem_write}.
- wb_ctrl  out  2  {reg_write, mem_to_reg}.
- ex_bus_a, ex_bus_b  out  DATA_W  registered operands.
- ex_immed  out  DATA_W  registered sign-extended immediate.
- ex_rs, ex_rt, ex_rd  out  5  registered register fields.

Behaviour:
- Reset (async, active-high): all ID/EX outputs and every register-bank entry go to 0; ex_valid=0.
- Register bank:
  - Write on the rising edge when wb_we && wb_rw!=0.
  - Reads are combinational. If wb_we && wb_rw==read addr && addr!=0, the read returns wb_data (same-cycle bypass).
  - Addresses >= NREG read as 0 and ignore writes.
- Immediate: sign-extend instr[15:0] to DATA_W.
- Decode by opcode instr[31:26]. Ctrl tuple (ex_ctrl, m_ctrl, wb_ctrl):
  - R 000000 -> (4'b1010, 00, 10).
  - ADDI 001000 -> (4'b0100, 00, 10).
  - LW 100011 -> (4'b0100, 10, 11).
  - SW 101011 -> (4'b0100, 01, 00).
  - BEQ 000100 / BNE 000101 -> (4'b0001, 00, 00).
  - Any other opcode -> all zero (NOP).
- EX destination: ex_rd if ex_ctrl[3], else ex_rt.
- Load-use hazard: if_valid && ex_valid && m_ctrl[1] && EX-dest!=0 && (EX-dest==rs || (EX-dest==rt && opcode uses rt as a source)). rt is a source for R, SW, BEQ and BNE.
- Branch hazard: if_valid && branch opcode && a source (rs/rt, nonzero) matches either:
  - the EX dest while wb_ctrl[1] && ex_valid, or
  - mem_dest while mem_reg_write.
- stall = load-use hazard || branch hazard.
- pc_sel = if_valid && !stall && ((BEQ && a==b) || (BNE && a!=b)).
- Clock edge, ID/EX register update:
  - stall=1: bubble. ex_valid=0, ctrl outputs zero; data fields don't-care but held.
  - !if_valid: bubble.
  - Otherwise: load decoded values, ex_valid=1.
  - Branch instructions travel to EX with their decoded (benign) ctrl.
- Latency: one cycle from IF/ID to ID/EX outputs. stall/pc_sel/branch_target are same-cycle combinational.
- Simultaneous hazard and branch: stall has priority and pc_sel stays 0. The branch re-evaluates next cycle.
- Reset mid-stall: bubble state is cleared immediately and stall recomputes from inputs.

Decomposition:
- Shared package/include dlx_defs: opcode constants, ctrl-field bit positions, bubble ctrl value.
- Sub-module: reg_bank_bypass (parametrised register bank with WB bypass), reused by later stages' tests.
- Hazard logic and decode stay inline.

Test Plan:
- Reset during operation -> ex_valid=0, all ctrl=0, r1..r31 read 0 next cycle.
- WB writes r5=0x1234 while ID reads ADD r5 -> ex_bus_a=0x1234 next edge. A write to r0 -> r0 still reads 0.
- LW r2,0(r1) in EX, then ADD r3,r2,r4 in ID -> stall=1 for exactly one cycle, one bubble (ex_valid=0). The ADD enters EX on the following edge.
- BEQ r1,r1,+5 at if_pc=0x3FE -> pc_sel=1, branch_target=0x003 (wrap). BNE with equal operands -> pc_sel=0.
- BEQ r7,r0 with ADDI r7 in EX -> stall 1 cycle. Then mem_reg_write on r7 -> stall again. Once r7 is in WB -> resolved using bypass data.
- Unknown opcode 111111 -> ex_valid=1, all ctrl=0. if_valid=0 -> bubble, pc_sel=0.
